// File: rtl/poly_wavetable_if.sv
// rtl/poly_wavetable_if.sv - config request and sample stream bundle for poly_wavetable (cfg_gain under OSC_GAIN_EN)
interface poly_wavetable_if #(
    parameter int VOICE_W = 2,
    parameter int PHASE_W = 32,
    parameter int OUT_W   = 16
);
    logic               cfg_valid;
    logic               cfg_ready;
    logic [VOICE_W-1:0] cfg_voice;
    logic [1:0]         cfg_mode;
    logic [PHASE_W-1:0] cfg_inc;
    logic               cfg_phase_clr;
`ifdef OSC_GAIN_EN
    logic [7:0]         cfg_gain;
`endif
    logic               out_valid;
    logic               out_ready;
    logic [OUT_W-1:0]   out_data;
    logic [VOICE_W-1:0] out_voice;
    logic               out_last;

`ifdef OSC_GAIN_EN
    modport master (output cfg_valid, cfg_voice, cfg_mode, cfg_inc, cfg_phase_clr, cfg_gain, out_ready,
                    input  cfg_ready, out_valid, out_data, out_voice, out_last);
    modport slave  (input  cfg_valid, cfg_voice, cfg_mode, cfg_inc, cfg_phase_clr, cfg_gain, out_ready,
                    output cfg_ready, out_valid, out_data, out_voice, out_last);
`else
    modport master (output cfg_valid, cfg_voice, cfg_mode, cfg_inc, cfg_phase_clr, out_ready,
                    input  cfg_ready, out_valid, out_data, out_voice, out_last);
    modport slave  (input  cfg_valid, cfg_voice, cfg_mode, cfg_inc, cfg_phase_clr, out_ready,
                    output cfg_ready, out_valid, out_data, out_voice, out_last);
`endif
endinterface

// File: rtl/poly_wavetable.sv
// rtl/poly_wavetable.sv - time-multiplexed N-voice wavetable oscillator, one frame per sample_tick
// Optional OSC_GAIN_EN adds per-voice 8-bit gain with one extra pipeline stage per voice.
module poly_wavetable #(
    parameter int N_VOICES   = 4,
    parameter int PHASE_W    = 32,
    parameter int OUT_W      = 16,
    parameter int LUT_ADDR_W = 10
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            sample_tick,
    poly_wavetable_if.slave bus,
    output logic            busy,
    output logic            overrun
);
    localparam int VOICE_W = $clog2(N_VOICES);
    localparam int MAX = 2 ** (OUT_W - 1) - 1;
    localparam int ROM_N = 2 ** LUT_ADDR_W;
    localparam real HALF_PI = 1.5707963267948966;
    localparam logic [VOICE_W-1:0] LAST = VOICE_W'(N_VOICES - 1);

    typedef enum logic [1:0] {IDLE, LOOKUP, GAIN, EMIT} state_t;

    function automatic logic [OUT_W-1:0] sine_entry(input int idx);
        real x;
        x = real'(MAX) * $sin(HALF_PI * real'(idx) / real'(ROM_N));
        return OUT_W'($rtoi(x + 0.5));
    endfunction

    logic [OUT_W-1:0] sine_rom [ROM_N];
    for (genvar i = 0; i < ROM_N; i++) begin : g_rom
        assign sine_rom[i] = sine_entry(i);
    end

    state_t              state;
    logic [VOICE_W-1:0]  voice;
    logic [PHASE_W-1:0]  phase [N_VOICES];
    logic [PHASE_W-1:0]  inc   [N_VOICES];
    logic [1:0]          mode  [N_VOICES];
    logic [LUT_ADDR_W-1:0] rom_addr;
    logic                rom_neg;
    logic                sel_sine;
    logic [OUT_W-1:0]    wave_q;

    logic [PHASE_W-1:0]    p;
    logic [LUT_ADDR_W-1:0] a_raw;
    logic [OUT_W-1:0]      tri_t;
    logic [OUT_W-1:0]      wave_next;
    logic [OUT_W-1:0]      sine_val;
    logic [OUT_W-1:0]      wave_out;

    assign p     = phase[voice];
    assign a_raw = p[PHASE_W-3 -: LUT_ADDR_W];

    // Non-sine shapes are computed during LOOKUP; sine waits for the registered ROM address.
    always_comb begin
        wave_next = '0;
        tri_t     = p[PHASE_W-1] ? ~p[PHASE_W-2 -: OUT_W] : p[PHASE_W-2 -: OUT_W];
        case (mode[voice])
            2'd1:    wave_next = {~p[PHASE_W-1], p[PHASE_W-2 -: OUT_W-1]};
            2'd2:    wave_next = p[PHASE_W-1] ? OUT_W'(-MAX) : OUT_W'(MAX);
            2'd3:    wave_next = {~tri_t[OUT_W-1], tri_t[OUT_W-2:0]};
            default: wave_next = '0;
        endcase
    end

    assign sine_val      = sine_rom[rom_addr];
    assign wave_out      = sel_sine ? (rom_neg ? -sine_val : sine_val) : wave_q;
    assign bus.cfg_ready = ~busy;

`ifdef OSC_GAIN_EN
    logic [7:0]            gain [N_VOICES];
    logic [OUT_W-1:0]      gain_q;
    logic signed [OUT_W+8:0] prod;
    assign prod         = $signed(wave_out) * $signed({1'b0, gain[voice]});
    assign bus.out_data = gain_q;
`else
    assign bus.out_data = wave_out;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            voice         <= '0;
            busy          <= 1'b0;
            overrun       <= 1'b0;
            bus.out_valid <= 1'b0;
            bus.out_voice <= '0;
            bus.out_last  <= 1'b0;
            rom_addr      <= '0;
            rom_neg       <= 1'b0;
            sel_sine      <= 1'b0;
            wave_q        <= '0;
            for (int i = 0; i < N_VOICES; i++) begin
                phase[i] <= '0;
                inc[i]   <= '0;
                mode[i]  <= '0;
`ifdef OSC_GAIN_EN
                gain[i]  <= '0;
`endif
            end
`ifdef OSC_GAIN_EN
            gain_q <= '0;
`endif
        end else begin
            if (bus.cfg_valid && !busy) begin
                mode[bus.cfg_voice] <= bus.cfg_mode;
                inc[bus.cfg_voice]  <= bus.cfg_inc;
`ifdef OSC_GAIN_EN
                gain[bus.cfg_voice] <= bus.cfg_gain;
`endif
                if (bus.cfg_phase_clr)
                    phase[bus.cfg_voice] <= '0;
            end

            // A tick landing on the final handshake chains straight into the next frame.
            overrun <= sample_tick && busy && !(state == EMIT && bus.out_ready && voice == LAST);

            case (state)
                IDLE: begin
                    if (sample_tick) begin
                        state <= LOOKUP;
                        voice <= '0;
                        busy  <= 1'b1;
                    end
                end
                LOOKUP: begin
                    phase[voice]  <= p + inc[voice];
                    rom_addr      <= p[PHASE_W-2] ? ~a_raw : a_raw;
                    rom_neg       <= p[PHASE_W-1];
                    sel_sine      <= (mode[voice] == 2'd0);
                    wave_q        <= wave_next;
                    bus.out_voice <= voice;
                    bus.out_last  <= (voice == LAST);
`ifdef OSC_GAIN_EN
                    state         <= GAIN;
`else
                    state         <= EMIT;
                    bus.out_valid <= 1'b1;
`endif
                end
`ifdef OSC_GAIN_EN
                GAIN: begin
                    gain_q        <= prod[OUT_W+7:8];
                    state         <= EMIT;
                    bus.out_valid <= 1'b1;
                end
`endif
                EMIT: begin
                    if (bus.out_ready) begin
                        bus.out_valid <= 1'b0;
                        bus.out_last  <= 1'b0;
                        if (voice == LAST) begin
                            voice <= '0;
                            if (sample_tick) begin
                                state <= LOOKUP;
                            end else begin
                                state <= IDLE;
                                busy  <= 1'b0;
                            end
                        end else begin
                            voice <= voice + 1'b1;
                            state <= LOOKUP;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_poly_wavetable.sv
// tb/tb_poly_wavetable.sv - randomized and directed self-checking bench for poly_wavetable
module tb_poly_wavetable;
    localparam int NV = 4;
`ifdef OSC_GAIN_EN
    localparam int LAT = 3;
    localparam int STEP = 3;
`else
    localparam int LAT = 2;
    localparam int STEP = 2;
`endif
    localparam real PI = 3.14159265358979323846;

    logic clk = 1'b0;
    logic reset;
    logic sample_tick;
    logic busy;
    logic overrun;

    poly_wavetable_if #(.VOICE_W(2), .PHASE_W(32), .OUT_W(16)) bus ();

    poly_wavetable dut (
        .clk         (clk),
        .reset       (reset),
        .sample_tick (sample_tick),
        .bus         (bus),
        .busy        (busy),
        .overrun     (overrun)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    bit [31:0] m_phase [NV];
    bit [31:0] m_inc   [NV];
    int        m_mode  [NV];
    int        m_gain  [NV];
    int        got     [NV];

    task automatic check(input string tag, input longint got_v, input longint exp_v);
        checks++;
        assert (got_v === exp_v) else begin
            errors++;
            $error("FAIL %s got %0d expected %0d", tag, got_v, exp_v);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NV; i++) begin
            m_phase[i] = '0; m_inc[i] = '0; m_mode[i] = 0; m_gain[i] = 0;
        end
    endtask

    function automatic int model_wave(input int m, input bit [31:0] p);
        int q, a, idx, u, t, w;
        case (m)
            0: begin
                q   = int'(p >> 30);
                a   = int'((p >> 20) & 32'd1023);
                idx = (q % 2 == 1) ? 1023 - a : a;
                w   = $rtoi($floor(32767.0 * $sin(PI / 2.0 * real'(idx) / 1024.0) + 0.5));
                if (q >= 2) w = -w;
            end
            1: w = int'(p >> 16) - 32768;
            2: w = (p < 32'h8000_0000) ? 32767 : -32767;
            default: begin
                u = int'((p >> 15) & 32'hFFFF);
                t = (p >= 32'h8000_0000) ? 65535 - u : u;
                w = t - 32768;
            end
        endcase
        return w;
    endfunction

    function automatic int model_sample(input int v);
        int w;
        w = model_wave(m_mode[v], m_phase[v]);
`ifdef OSC_GAIN_EN
        w = (w * m_gain[v]) >>> 8;
`endif
        m_phase[v] = m_phase[v] + m_inc[v];
        return w;
    endfunction

    task automatic cfg(input int v, input int m, input bit [31:0] i, input bit clr, input int g);
        check("cfg_ready_idle", bus.cfg_ready, 1);
        bus.cfg_valid = 1'b1; bus.cfg_voice = v[1:0]; bus.cfg_mode = m[1:0];
        bus.cfg_inc = i; bus.cfg_phase_clr = clr;
`ifdef OSC_GAIN_EN
        bus.cfg_gain = g[7:0];
`endif
        @(posedge clk); #1;
        bus.cfg_valid = 1'b0;
        m_mode[v] = m; m_inc[v] = i; m_gain[v] = g;
        if (clr) m_phase[v] = '0;
    endtask

    task automatic stall(input int w, input int b);
        bus.out_ready = 1'b0;
        bus.cfg_valid = 1'b1; bus.cfg_voice = 2'd0; bus.cfg_mode = 2'd1;
        bus.cfg_inc = 32'h1234; bus.cfg_phase_clr = 1'b1;
        for (int k = 0; k < 10; k++) begin
            sample_tick = (k == 2);
            @(posedge clk); #1;
            check("stall_valid", bus.out_valid, 1);
            check("stall_data", $signed(bus.out_data), w);
            check("stall_voice", bus.out_voice, b);
            check("cfg_ready_busy", bus.cfg_ready, 0);
            check("overrun", overrun, (k == 2) ? 1 : 0);
        end
        sample_tick = 1'b0; bus.cfg_valid = 1'b0; bus.out_ready = 1'b1;
    endtask

    task automatic frame(input int stall_beat);
        int beats, cyc, first_cyc, last_cyc, w;
        beats = 0; first_cyc = -1; last_cyc = -1;
        sample_tick = 1'b1;
        @(posedge clk); #1;
        sample_tick = 1'b0;
        cyc = 1;
        while (beats < NV && cyc < 60) begin
            if (bus.out_valid) begin
                w = model_sample(beats);
                check("voice", bus.out_voice, beats);
                check("last", bus.out_last, (beats == NV - 1) ? 1 : 0);
                check("data", $signed(bus.out_data), w);
                got[beats] = int'($signed(bus.out_data));
                if (beats == 0) first_cyc = cyc;
                last_cyc = cyc;
                if (beats == stall_beat) stall(w, beats);
                beats++;
            end
            @(posedge clk); #1;
            cyc++;
        end
        check("beats", beats, NV);
        if (stall_beat < 0) begin
            check("latency", first_cyc, LAT);
            check("frame_len", last_cyc, LAT + (NV - 1) * STEP);
            check("busy_end", busy, 0);
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int sq_exp [3];
        int saw_exp [5];
        int sin_exp [4];
        int tri_exp [4];
        int seen;
        sq_exp  = '{32767, -32767, 32767};
        saw_exp = '{-32768, -16384, 0, 16384, -32768};
        sin_exp = '{0, 32767, 0, -32767};
        tri_exp = '{-32768, 0, 32767, -1};

        reset = 1'b1; sample_tick = 1'b0;
        bus.cfg_valid = 1'b0; bus.cfg_voice = '0; bus.cfg_mode = '0;
        bus.cfg_inc = '0; bus.cfg_phase_clr = 1'b0; bus.out_ready = 1'b1;
`ifdef OSC_GAIN_EN
        bus.cfg_gain = '0;
`endif
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_out_data", bus.out_data, 0);
        check("rst_out_voice", bus.out_voice, 0);
        check("rst_out_last", bus.out_last, 0);
        check("rst_busy", busy, 0);
        check("rst_overrun", overrun, 0);
        check("rst_cfg_ready", bus.cfg_ready, 1);

        frame(-1);

        cfg(0, 2, 32'h8000_0000, 1'b1, 128);
        for (int i = 0; i < 3; i++) begin
            frame(-1);
`ifdef OSC_GAIN_EN
            check("square_gain_v0", got[0], (sq_exp[i] * 128) >>> 8);
`else
            check("square_v0", got[0], sq_exp[i]);
`endif
        end

        cfg(1, 1, 32'h4000_0000, 1'b1, 128);
        for (int i = 0; i < 5; i++) begin
            frame(-1);
`ifndef OSC_GAIN_EN
            check("saw_v1", got[1], saw_exp[i]);
`endif
        end

        cfg(2, 0, 32'h4000_0000, 1'b1, 128);
        cfg(3, 3, 32'h4000_0000, 1'b1, 128);
        for (int i = 0; i < 4; i++) begin
            frame(-1);
`ifndef OSC_GAIN_EN
            check("sine_v2", got[2], sin_exp[i]);
            check("tri_v3", got[3], tri_exp[i]);
`endif
        end

        for (int r = 0; r < 10; r++) begin
            cfg(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), $urandom,
                1'($urandom_range(0, 1)), int'($urandom_range(0, 255)));
            frame(-1);
            frame(-1);
        end

        frame(1);
        seen = 0;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #1;
            if (bus.out_valid || busy) seen++;
        end
        check("no_extra_frame", seen, 0);
        frame(-1);

        sample_tick = 1'b1;
        @(posedge clk); #1;
        sample_tick = 1'b0;
        seen = 0;
        for (int k = 0; k < 10 && seen == 0; k++) begin
            if (bus.out_valid) seen = 1;
            else begin @(posedge clk); #1; end
        end
        check("midframe_valid_seen", seen, 1);
        reset = 1'b1;
        @(posedge clk); #1;
        check("midrst_out_valid", bus.out_valid, 0);
        check("midrst_out_last", bus.out_last, 0);
        check("midrst_busy", busy, 0);
        reset = 1'b0;
        model_reset();
        frame(-1);
        check("post_rst_data_v2", got[2], 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
